// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the instruction sequencer and opcode decoder:
// state encodings, opcode constants and the watchdog limit default.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } seq_state_e;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_DIV  = 4'h6;
    localparam logic [3:0] OP_JAL  = 4'h7;
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_LUI  = 4'h9;
    localparam logic [3:0] OP_J    = 4'hA;
    localparam logic [3:0] OP_JR   = 4'hB;
    localparam logic [3:0] OP_LW   = 4'hC;
    localparam logic [3:0] OP_SW   = 4'hD;
    localparam logic [3:0] OP_SLT  = 4'hE;
    localparam logic [3:0] OP_SGT  = 4'hF;

    localparam int WDOG_LIMIT_DEFAULT = 255;

endpackage

// File: rtl/instr_sequencer_if.sv
// Request/acknowledge signals between the sequencer and instruction memory,
// data memory and the multiply/divide unit.
// A request (imem_rd, dmem_rd, dmem_wr) stays high until its ack is seen in the
// same cycle; alu_start and alu_done are single-cycle pulses.
interface instr_sequencer_if;

    logic imem_rd;
    logic imem_ack;
    logic dmem_rd;
    logic dmem_wr;
    logic mem_ack;
    logic alu_start;
    logic alu_done;

    modport master (
        output imem_rd,
        output dmem_rd,
        output dmem_wr,
        output alu_start,
        input  imem_ack,
        input  mem_ack,
        input  alu_done
    );

    modport slave (
        input  imem_rd,
        input  dmem_rd,
        input  dmem_wr,
        input  alu_start,
        output imem_ack,
        output mem_ack,
        output alu_done
    );

endinterface

// File: rtl/seq_op_class.sv
// Combinational opcode classifier shared by the sequencer and the opcode decoder.
module seq_op_class
    import cpu_seq_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       is_muldiv,
    output logic       is_load,
    output logic       is_store,
    output logic       writes_rf
);

    always_comb begin
        is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
        is_load   = (opcode == OP_LW);
        is_store  = (opcode == OP_SW);
        case (opcode)
            OP_NOP, OP_J, OP_JR, OP_SW: writes_rf = 1'b0;
            default:                    writes_rf = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit RISC core.
// Define SEQ_WATCHDOG_EN to build the wait-cycle watchdog and FAULT state.
// Handshake: imem_rd, dmem_rd and dmem_wr are held high until the matching ack is
// seen in the same cycle; alu_start and alu_done are single-cycle pulses.
module instr_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int WDOG_LIMIT = WDOG_LIMIT_DEFAULT
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  opcode,
  input  logic        imem_ack,
  input  logic        mem_ack,
  input  logic        alu_done,
  input  logic        halt_req,
  output logic        imem_rd,
  output logic        ir_en,
  output logic        pc_en,
  output logic        alu_start,
  output logic        dmem_rd,
  output logic        dmem_wr,
  output logic        rf_wr_en,
  output logic [2:0]  state,
  output logic        halted,
  output logic        fault,
  output logic [15:0] instr_cnt
);

  seq_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        is_muldiv, is_load, is_store, writes_rf;
  logic        retire;
  logic        imem_rd_c, dmem_rd_c, dmem_wr_c, alu_start_c;
  logic        wdog_hit;

  seq_op_class u_op_class (
    .opcode    (opcode),
    .is_muldiv (is_muldiv),
    .is_load   (is_load),
    .is_store  (is_store),
    .writes_rf (writes_rf)
  );

`ifdef SEQ_WATCHDOG_EN
  localparam logic [7:0] WDOG_LAST = 8'(WDOG_LIMIT - 1);

  logic [7:0] wdog_q, wdog_d;
  logic       waiting;

  // Any cycle that is not a wait (including every state change) clears the count.
  always_comb begin
    waiting  = ((state_q == S_FETCH) && !imem_ack) ||
               ((state_q == S_EXEC) && is_muldiv && !alu_done) ||
               ((state_q == S_MEM) && !mem_ack);
    wdog_hit = waiting && (wdog_q == WDOG_LAST);
    wdog_d   = (waiting && !wdog_hit) ? wdog_q + 8'd1 : 8'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= 8'd0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  assign fault = !rst && (state_q == S_FAULT);
`else
  assign wdog_hit = 1'b0;
  assign fault    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retire      = 1'b0;
    imem_rd_c   = 1'b0;
    dmem_rd_c   = 1'b0;
    dmem_wr_c   = 1'b0;
    alu_start_c = 1'b0;
    ir_en       = 1'b0;
    pc_en       = 1'b0;
    rf_wr_en    = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_rd_c = 1'b1;
        if (imem_ack) begin
          ir_en   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_start_c = is_muldiv;
        state_d     = S_EXEC;
      end
      S_EXEC: begin
        if (!is_muldiv || alu_done) begin
          if (is_load || is_store) begin
            state_d = S_MEM;
          end else if (writes_rf) begin
            state_d = S_WB;
          end else begin
            retire = 1'b1;
          end
        end
      end
      S_MEM: begin
        dmem_rd_c = is_load;
        dmem_wr_c = is_store;
        if (mem_ack) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            retire = 1'b1;
          end
        end
      end
      S_WB: begin
        rf_wr_en = 1'b1;
        retire   = 1'b1;
      end
      S_HALT: begin
        if (!halt_req) begin
          state_d = S_FETCH;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    if (retire) begin
      pc_en   = 1'b1;
      cnt_d   = cnt_q + 16'd1;
      state_d = halt_req ? S_HALT : S_FETCH;
    end

    if (wdog_hit) begin
      state_d = S_FAULT;
    end

    // Outputs read as all-zero while reset is held, whatever the old state was.
    if (rst) begin
      imem_rd_c   = 1'b0;
      dmem_rd_c   = 1'b0;
      dmem_wr_c   = 1'b0;
      alu_start_c = 1'b0;
      ir_en       = 1'b0;
      pc_en       = 1'b0;
      rf_wr_en    = 1'b0;
    end
  end

  assign imem_rd   = imem_rd_c;
  assign dmem_rd   = dmem_rd_c;
  assign dmem_wr   = dmem_wr_c;
  assign alu_start = alu_start_c;

  assign state     = rst ? 3'd0 : state_q;
  assign halted    = !rst && (state_q == S_HALT);
  assign instr_cnt = rst ? 16'd0 : cnt_q;

endmodule
